serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
- Bit-serial multi-bit adder that computes a WIDTH-bit add using one full_adder instance, one bit per clock, LSB first.
- Contains the sequencer: start/ready/done handshake, bit counter, operand shift registers, carry flip-flop and result register.
- Trades WIDTH+2 cycles of throughput for a single full-adder cell.
- Used wherever a narrow-area adder is acceptable in place of a ripple-carry chain.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request to begin an add; sampled only in IDLE.
- a  in  WIDTH  operand A; captured on the accepted start.
- b  in  WIDTH  operand B; captured on the accepted start.
- c_in  in  1  carry-in; captured on the accepted start.
- ready  out  1  high in IDLE; start is accepted only when ready=1.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; result outputs are valid from this cycle onward.
- sum  out  WIDTH  registered result; holds until the next completion.
- carry  out  1  registered carry-out of the MSB.
- overflow  out  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async, rst=1): state=IDLE, ready=1, busy=0, done=0, sum=0, carry=0, overflow=0; internal shift regs, counter and carry FF cleared.
- Reset asserted mid-operation aborts the add: no done pulse; sum, carry and overflow go to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - If start=1: load a and b into shift regs, carry FF<=c_in, counter<=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - ready=0, busy=1.
  - Each cycle, the full_adder takes the LSB of each shift reg plus the carry FF.
  - Its sum bit shifts into the result shift reg from the MSB side (right shift).
  - Carry FF <= full_adder carry; both operand regs shift right by 1.
  - Before updating, the carry FF value on the MSB step (counter==WIDTH-1) is recorded as carry-into-MSB.
  - When counter==WIDTH-1, go to DONE on that edge. Otherwise counter++.
  - Exactly WIDTH RUN cycles.
- DONE (one cycle):
  - The final result reg, carry FF and overflow are copied into sum, carry and overflow on the RUN->DONE edge.
  - done=1, busy=1, ready=0.
  - Unconditionally go to IDLE.
- Output stability: sum, carry and overflow change only on the RUN->DONE edge. They hold the previous result during RUN and after DONE until the next completion.
- Latency: start accepted on edge T -> done high during cycle T+WIDTH+1. Minimum start-to-start spacing is WIDTH+2 cycles.
- A start in RUN or DONE is ignored: no queuing and no effect on the in-flight add. Operand changes after acceptance have no effect.
- Arithmetic: {carry,sum} = a + b + c_in modulo 2^(WIDTH+1), with no truncation of carry.
- WIDTH=1: a single RUN cycle; carry-into-MSB = c_in.
- Counter width is $clog2(WIDTH)+1 bits, so there is no wrap before the terminal count.
- The full_adder instance and the inputs of both half_adders are fully connected; no floating ports.

Test Plan:
- WIDTH=8, a=8'h5A, b=8'h3C, c_in=0, start at edge T -> done pulse in cycle T+9, sum=8'h96, carry=0, overflow=1.
- a=8'hFF, b=8'h01, c_in=0 -> sum=8'h00, carry=1, overflow=0; sum holds 8'h96 from the previous add throughout RUN.
- a=8'hFF, b=8'hFF, c_in=1 -> sum=8'hFF, carry=1, overflow=0. Also a=8'h80, b=8'h80, c_in=0 -> sum=8'h00, carry=1, overflow=1.
- Pulse start with a=8'h01 three cycles into RUN of 8'h10+8'h20 -> ignored; single done, sum=8'h30, ready stays 0 until IDLE.
- Assert rst for one cycle at RUN cycle 4 -> outputs 0 immediately (asynchronous), no done pulse, ready=1 after release; the next add of 8'h03+8'h04 returns 8'h07.
- Hold start high continuously with random operands for 50 adds -> done every 10 cycles; every result matches the reference a+b+c_in. Repeat at WIDTH=1 (done every 3 cycles, all 8 input combos correct).

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial WIDTH-bit adder built on one full_adder cell
//
// half_adder : s = a ^ b, c = a & b
// full_adder : two half_adders plus an OR for the carry
//   a, b, c_in   operand bits and carry-in
//   s, c_out     sum bit and carry-out
// serial_adder_ctrl : adds one bit per clock, LSB first
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        begin an add; taken only while ready=1
//   a, b, c_in   operands and carry-in, captured on the accepted start
//   ready        high in IDLE
//   busy         high in RUN and DONE
//   done         one-cycle pulse; results valid from this cycle on
//   sum          registered WIDTH-bit result, held until the next completion
//   carry        registered carry-out of the MSB
//   overflow     signed overflow (carry into MSB ^ carry out of MSB)

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  logic s0, c0, c1;

  half_adder ha0 (.a(a),  .b(b),    .s(s0), .c(c0));
  half_adder ha1 (.a(s0), .b(c_in), .s(s),  .c(c1));

  assign c_out = c0 | c1;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);
  // One extra bit so the counter reaches WIDTH-1 without wrapping, even at WIDTH=1.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_next;
  logic            load, step, last;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_next;
  logic            cy;
  logic [CW-1:0]   cnt;
  logic            fa_s, fa_co;

  full_adder fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .c_in (cy),
    .s    (fa_s),
    .c_out(fa_co)
  );

  // New sum bit enters from the MSB side so that after WIDTH steps the
  // first (LSB) sum bit has arrived at bit 0.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_next = fa_s;
    end else begin : g_res_wn
      assign res_next = {fa_s, res_sr[WIDTH-1:1]};
    end
  endgenerate

  assign last = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      cy       <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else if (load) begin
      a_sr <= a;
      b_sr <= b;
      cy   <= c_in;
      cnt  <= '0;
    end else if (step) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_next;
      cy     <= fa_co;
      if (last) begin
        // On the MSB step cy still holds the carry into the MSB, so the
        // overflow term is formed before cy is overwritten.
        sum      <= res_next;
        carry    <= fa_co;
        overflow <= cy ^ fa_co;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst8, start8, cin8;
  logic [7:0] a8, b8;
  logic       ready8, busy8, done8, carry8, ovf8;
  logic [7:0] sum8;

  logic       rst1, start1, cin1;
  logic [0:0] a1, b1;
  logic       ready1, busy1, done1, carry1, ovf1;
  logic [0:0] sum1;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .c_in(cin8),
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .carry(carry8), .overflow(ovf8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1), .c_in(cin1),
    .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .carry(carry1), .overflow(ovf1)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Reference: {overflow, carry, sum}; overflow from the sign rule, not the carry chain.
  function automatic logic [9:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic ci);
    logic [8:0] s;
    logic       v;
    s = {1'b0, x} + {1'b0, y} + {8'b0, ci};
    v = (x[7] == y[7]) && (s[7] != x[7]);
    return {v, s};
  endfunction

  function automatic logic [2:0] ref1(input logic x, input logic y, input logic ci);
    logic [1:0] s;
    logic       v;
    s = {1'b0, x} + {1'b0, y} + {1'b0, ci};
    v = (x == y) && (s[0] != x);
    return {v, s};
  endfunction

  // Scoreboards and monitors
  logic [9:0] q8[$];
  logic [2:0] q1[$];
  int  acc8 = 0, acc1 = 0;
  bit  lat8 = 0, lat1 = 0, spc8 = 0, spc1 = 0;
  int  last8 = -1, last1 = -1;

  always @(negedge clk) begin
    if (!rst8 && done8) begin
      if (q8.size() == 0) fail_now("unexpected_done8");
      else begin
        chk("result8", {22'b0, ovf8, carry8, sum8}, {22'b0, q8.pop_front()});
        if (lat8) chk("latency8", cyc - acc8, 8);
        if (spc8 && last8 >= 0) chk("spacing8", cyc - last8, 10);
        last8 = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst1 && done1) begin
      if (q1.size() == 0) fail_now("unexpected_done1");
      else begin
        chk("result1", {29'b0, ovf1, carry1, sum1}, {29'b0, q1.pop_front()});
        if (lat1) chk("latency1", cyc - acc1, 1);
        if (spc1 && last1 >= 0) chk("spacing1", cyc - last1, 3);
        last1 = cyc;
      end
    end
  end

  task automatic wait_ready8();
    int k = 0;
    @(negedge clk);
    while (!ready8 && k < 40) begin @(negedge clk); k++; end
    if (!ready8) fail_now("timeout_ready8");
  endtask

  task automatic wait_ready1();
    int k = 0;
    @(negedge clk);
    while (!ready1 && k < 20) begin @(negedge clk); k++; end
    if (!ready1) fail_now("timeout_ready1");
  endtask

  task automatic wait_done8();
    int k = 0;
    @(negedge clk);
    while (!done8 && k < 20) begin @(negedge clk); k++; end
    if (!done8) fail_now("timeout_done8");
  endtask

  // Issue one add on dut8; expectation pushed only when the add is meant to finish.
  task automatic issue8(input logic [7:0] x, input logic [7:0] y, input logic ci,
                        input logic [9:0] exp, input bit push);
    wait_ready8();
    a8 = x; b8 = y; cin8 = ci; start8 = 1'b1;
    if (push) q8.push_back(exp);
    @(posedge clk); #1;
    acc8 = cyc;
    start8 = 1'b0;
  endtask

  // Directed table with hand-computed {overflow, carry, sum}
  logic [7:0] ta[4]   = '{8'h5A, 8'hFF, 8'hFF, 8'h80};
  logic [7:0] tb[4]   = '{8'h3C, 8'h01, 8'hFF, 8'h80};
  logic       tc[4]   = '{1'b0,  1'b0,  1'b1,  1'b0};
  logic [9:0] texp[4] = '{{2'b10, 8'h96}, {2'b01, 8'h00}, {2'b01, 8'hFF}, {2'b11, 8'h00}};

  initial begin
    rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    rst1 = 1'b1; start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    #2;
    chk("rst_ready8", ready8, 1);
    chk("rst_busy8",  busy8,  0);
    chk("rst_done8",  done8,  0);
    chk("rst_out8",   {ovf8, carry8, sum8}, 0);
    chk("rst_ready1", ready1, 1);
    chk("rst_out1",   {done1, busy1, ovf1, carry1, sum1}, 0);
    @(posedge clk); #1;
    rst8 = 1'b0; rst1 = 1'b0;

    // Directed vectors; the second also checks sum holds the first result during RUN.
    lat8 = 1;
    for (int i = 0; i < 4; i++) begin
      issue8(ta[i], tb[i], tc[i], texp[i], 1);
      if (i == 1) begin
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (done8) break;
          chk("hold_during_run8", sum8, 8'h96);
        end
      end else begin
        wait_done8();
      end
    end

    // Start pulse three cycles into RUN must be ignored.
    issue8(8'h10, 8'h20, 1'b0, {2'b00, 8'h30}, 1);
    repeat (3) @(posedge clk);
    #1;
    a8 = 8'h01; start8 = 1'b1;
    chk("ready_in_run8", ready8, 0);
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'h00;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done8) break;
      chk("ready_low_busy8", ready8, 0);
    end

    // Reset in RUN cycle 4 aborts the add; outputs clear at once.
    issue8(8'h11, 8'h22, 1'b0, 10'h0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst8 = 1'b1;
    #1;
    chk("abort_out8",   {ovf8, carry8, sum8}, 0);
    chk("abort_ready8", ready8, 1);
    chk("abort_busy8",  {busy8, done8}, 0);
    @(posedge clk); #1;
    rst8 = 1'b0;
    chk("post_abort_ready8", ready8, 1);
    issue8(8'h03, 8'h04, 1'b0, {2'b00, 8'h07}, 1);
    wait_done8();

    // Back-to-back adds with start held high.
    lat8 = 0; spc8 = 1; last8 = -1;
    start8 = 1'b1;
    for (int i = 0; i < 50; i++) begin
      wait_ready8();
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      q8.push_back(ref8(a8, b8, cin8));
      @(posedge clk);
    end
    #1 start8 = 1'b0;
    for (int k = 0; k < 40 && q8.size() != 0; k++) @(negedge clk);
    chk("drain8", q8.size(), 0);
    spc8 = 0;

    // WIDTH=1: single directed add for latency, then all 8 combos back to back.
    lat1 = 1;
    wait_ready1();
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
    q1.push_back(3'b011);
    @(posedge clk); #1;
    acc1 = cyc; start1 = 1'b0;
    lat1 = 0; spc1 = 1; last1 = -1;
    start1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      wait_ready1();
      a1 = v[2]; b1 = v[1]; cin1 = v[0];
      q1.push_back(ref1(v[2], v[1], v[0]));
      @(posedge clk);
    end
    #1 start1 = 1'b0;
    for (int k = 0; k < 20 && q1.size() != 0; k++) @(negedge clk);
    chk("drain1", q1.size(), 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
